noc_input_port: RTL and testbench

- Requester-side port controller for the round-robin crossbar. One instance per crossbar input.
- Buffers flits arriving from a link in a FIFO and decodes the destination field of the head flit.
- Drives data, dest and dest_en into the crossbar, then consumes ack and routed backpressure to decide when a flit has left.
- Generates link-level backpressure toward the upstream sender.

---
 rtl/noc_pkg.sv | 25 ++
 rtl/noc_input_port_sync_fifo.sv | 61 ++++++
 rtl/noc_input_port.sv | 161 ++++++++++++++++
 tb/tb_noc_input_port.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared types and helpers for the NoC input port.
// State encoding for the input-port controller, the backpressure stop-bit
// index and the destination-field extractor.
package noc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    REQ  = 2'd2
  } inport_state_t;

  // Bit of a backpressure vector that means "stop sending".
  localparam int BP_STOP = 0;

  // Widest flit the destination extractor accepts.
  localparam int FLIT_MAX_W = 64;

  // Extract a w-bit destination field located at bit lsb of a flit.
  function automatic logic [31:0] dest_of(input logic [FLIT_MAX_W-1:0] flit,
                                          input int unsigned           lsb,
                                          input int unsigned           w);
    return 32'(flit >> lsb) & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/noc_input_port_sync_fifo.sv
// sync_fifo: single-clock FIFO storage for the NoC input port.
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
// The caller guarantees push only when not full (or popping in the same
// cycle) and pop only when not empty.
module sync_fifo
  import noc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Storage write; data is not reset, the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({push, pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);

endmodule

// File: rtl/noc_input_port.sv
// noc_input_port: requester-side controller for one crossbar input.
// Buffers link flits in a FIFO, moves the head flit into an output
// register, decodes its destination and requests the crossbar until the
// flit is granted without backpressure. Invalid destinations are dropped.
// Optional build macro NOC_INPORT_STATS_EN adds saturating transfer and
// stall counters (stat_fwd_o / stat_stall_o).
module noc_input_port
  import noc_pkg::*;
#(
  parameter  int PORTS    = 2,
  parameter  int WIDTH    = 8,
  parameter  int BP_WIDTH = 1,
  parameter  int DEPTH    = 4,
  parameter  int DEST_LSB = 0,
  localparam int DEST_W   = $clog2(PORTS),
  localparam int CNT_W    = $clog2(DEPTH+1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    in_data,
  input  logic                in_valid,
  output logic [BP_WIDTH-1:0] in_bp_o,
  output logic [WIDTH-1:0]    xbar_data_o,
  output logic [DEST_W-1:0]   xbar_dest_o,
  output logic                xbar_dest_en_o,
  input  logic                xbar_ack_i,
  input  logic [BP_WIDTH-1:0] xbar_bp_i,
  output logic                drop_o,
  output logic                ovf_o,
  output logic [CNT_W-1:0]    count_o
`ifdef NOC_INPORT_STATS_EN
  ,
  output logic [31:0]         stat_fwd_o,
  output logic [31:0]         stat_stall_o
`endif
);

  inport_state_t     r_state;
  inport_state_t     w_next_state;
  logic [WIDTH-1:0]  w_fifo_dout;
  logic [CNT_W-1:0]  w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic              w_dest_en;
  logic              w_transfer;
  logic              w_dest_bad;
  logic [WIDTH-1:0]  r_data;
  logic [DEST_W-1:0] r_dest;
  logic              r_valid;
  logic              w_unused_bp;

  // Only the stop bit of the routed backpressure is meaningful.
  assign w_unused_bp = ^xbar_bp_i;
  assign w_transfer  = xbar_ack_i && !xbar_bp_i[BP_STOP];
  assign w_dest_bad  = (32'(r_dest) >= 32'(PORTS));

  // A full FIFO still accepts a flit when a pop frees a slot this cycle.
  assign w_push = in_valid && (!w_full || w_pop);

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (in_data),
    .dout  (w_fifo_dout),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // FSM next-state: every exit from a finished flit reloads if data waits.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_pop) w_next_state = LOAD;
      LOAD:    if (w_dest_bad) w_next_state = w_pop ? LOAD : IDLE;
               else            w_next_state = REQ;
      REQ:     if (w_transfer) w_next_state = w_pop ? LOAD : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // FSM outputs: pop, drop pulse and crossbar request.
  always_comb begin
    w_pop     = 1'b0;
    w_drop    = 1'b0;
    w_dest_en = 1'b0;
    case (r_state)
      IDLE: w_pop = !w_empty;
      LOAD: begin
        if (w_dest_bad) begin
          w_drop = 1'b1;
          w_pop  = !w_empty;
        end
      end
      REQ: begin
        w_dest_en = 1'b1;
        if (w_transfer) w_pop = !w_empty;
      end
      default: ;
    endcase
  end

  // Output register valid bit: set on load, cleared when the flit leaves.
  always_ff @(posedge clk) begin
    if (rst)                                            r_valid <= 1'b0;
    else if (w_pop)                                     r_valid <= 1'b1;
    else if ((r_state == LOAD && w_dest_bad) ||
             (r_state == REQ && w_transfer))            r_valid <= 1'b0;
  end

  // Output register payload; qualified by r_valid so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_data <= w_fifo_dout;
      r_dest <= DEST_W'(dest_of(FLIT_MAX_W'(w_fifo_dout), DEST_LSB, DEST_W));
    end
  end

`ifdef NOC_INPORT_STATS_EN
  logic [31:0] r_stat_fwd;
  logic [31:0] r_stat_stall;

  // Saturating counters of completed transfers and stalled request cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_fwd   <= '0;
      r_stat_stall <= '0;
    end else if (r_state == REQ) begin
      if (w_transfer && r_stat_fwd != '1)    r_stat_fwd   <= r_stat_fwd + 32'd1;
      if (!w_transfer && r_stat_stall != '1) r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_fwd_o   = r_stat_fwd;
  assign stat_stall_o = r_stat_stall;
`endif

  // One slot of slack covers the upstream's sampling delay of in_bp_o.
  assign in_bp_o        = BP_WIDTH'(w_count >= CNT_W'(DEPTH-1));
  assign xbar_data_o    = r_valid ? r_data : '0;
  assign xbar_dest_o    = r_valid ? r_dest : '0;
  assign xbar_dest_en_o = w_dest_en;
  assign drop_o         = w_drop;
  assign ovf_o          = in_valid && w_full && !w_pop;
  assign count_o        = w_count;

endmodule

// File: tb/tb_noc_input_port.sv
// Directed testbench for noc_input_port (PORTS=3, WIDTH=8, DEPTH=4).
module tb_noc_input_port;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic [0:0] in_bp_o;
  logic [7:0] xbar_data_o;
  logic [1:0] xbar_dest_o;
  logic       xbar_dest_en_o;
  logic       xbar_ack_i;
  logic [0:0] xbar_bp_i;
  logic       drop_o;
  logic       ovf_o;
  logic [2:0] count_o;
`ifdef NOC_INPORT_STATS_EN
  logic [31:0] stat_fwd_o;
  logic [31:0] stat_stall_o;
`endif

  int checks = 0;
  int errors = 0;

  noc_input_port #(
    .PORTS    (3),
    .WIDTH    (8),
    .BP_WIDTH (1),
    .DEPTH    (4),
    .DEST_LSB (0)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_bp_o        (in_bp_o),
    .xbar_data_o    (xbar_data_o),
    .xbar_dest_o    (xbar_dest_o),
    .xbar_dest_en_o (xbar_dest_en_o),
    .xbar_ack_i     (xbar_ack_i),
    .xbar_bp_i      (xbar_bp_i),
    .drop_o         (drop_o),
    .ovf_o          (ovf_o),
    .count_o        (count_o)
`ifdef NOC_INPORT_STATS_EN
    ,
    .stat_fwd_o     (stat_fwd_o),
    .stat_stall_o   (stat_stall_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_req(input string tag, input logic en, input logic [1:0] dst,
                         input logic [7:0] dat);
    check({tag, "_en"},   32'(xbar_dest_en_o), 32'(en));
    check({tag, "_dest"}, 32'(xbar_dest_o),    32'(dst));
    check({tag, "_data"}, 32'(xbar_data_o),    32'(dat));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic a, input logic b);
    in_valid   = v;
    in_data    = d;
    xbar_ack_i = a;
    xbar_bp_i  = b;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 8'h00, 0, 0);
    cyc();
    cyc();
    rst = 1'b0;
    drive(0, 8'h00, 0, 0);
    // Reset state
    chk_req("rst", 0, 2'd0, 8'h00);
    check("rst_count", 32'(count_o), 0);
    check("rst_bp",    32'(in_bp_o), 0);
    check("rst_drop",  32'(drop_o),  0);
    check("rst_ovf",   32'(ovf_o),   0);
    cyc();

    // Single flit, ack tied high: request appears three cycles after push
    drive(1, 8'h01, 1, 0);
    cyc();
    drive(0, 8'h00, 1, 0);
    check("t1_c1_count", 32'(count_o), 1);
    check("t1_c1_en",    32'(xbar_dest_en_o), 0);
    cyc();
    check("t1_c2_en",    32'(xbar_dest_en_o), 0);
    check("t1_c2_count", 32'(count_o), 0);
    cyc();
    chk_req("t1_c3", 1, 2'd1, 8'h01);
    cyc();
    chk_req("t1_c4", 0, 2'd0, 8'h00);
    check("t1_c4_count", 32'(count_o), 0);
    cyc();

    // Fill with ack low: backpressure at 3, overflow at 4
    drive(1, 8'h40, 0, 0);
    cyc();
    drive(1, 8'h41, 0, 0);
    check("t2_c1_bp", 32'(in_bp_o), 0);
    cyc();
    drive(1, 8'h42, 0, 0);
    check("t2_c2_count", 32'(count_o), 1);
    cyc();
    drive(1, 8'h50, 0, 0);
    chk_req("t2_c3", 1, 2'd0, 8'h40);
    check("t2_c3_count", 32'(count_o), 2);
    check("t2_c3_bp",    32'(in_bp_o), 0);
    cyc();
    drive(1, 8'h51, 0, 0);
    check("t2_c4_count", 32'(count_o), 3);
    check("t2_c4_bp",    32'(in_bp_o), 1);
    check("t2_c4_ovf",   32'(ovf_o),   0);
    cyc();
    drive(1, 8'h52, 0, 0);
    check("t2_c5_count", 32'(count_o), 4);
    check("t2_c5_ovf",   32'(ovf_o),   1);
    check("t2_c5_bp",    32'(in_bp_o), 1);
    cyc();

    // Grant with backpressure for three cycles, then release
    drive(0, 8'h00, 1, 1);
    check("t3_c6_count", 32'(count_o), 4);
    check("t3_c6_ovf",   32'(ovf_o),   0);
    chk_req("t3_c6", 1, 2'd0, 8'h40);
    cyc();
    chk_req("t3_c7", 1, 2'd0, 8'h40);
    check("t3_c7_count", 32'(count_o), 4);
    cyc();
    chk_req("t3_c8", 1, 2'd0, 8'h40);
    cyc();
    drive(0, 8'h00, 1, 0);
    chk_req("t3_c9", 1, 2'd0, 8'h40);
    cyc();
    check("t3_c10_en",    32'(xbar_dest_en_o), 0);
    check("t3_c10_count", 32'(count_o), 3);
    cyc();
    chk_req("t3_c11", 1, 2'd1, 8'h41);
    cyc();
    check("t3_c12_en", 32'(xbar_dest_en_o), 0);
    cyc();
    chk_req("t3_c13", 1, 2'd2, 8'h42);
    check("t3_c13_count", 32'(count_o), 2);
    cyc();
    cyc();
    chk_req("t3_c15", 1, 2'd0, 8'h50);
    cyc();
    cyc();
    chk_req("t3_c17", 1, 2'd1, 8'h51);
    cyc();
    chk_req("t3_c18", 0, 2'd0, 8'h00);
    check("t3_c18_count", 32'(count_o), 0);
    cyc();

    // Invalid destination 3 is dropped, the next flit (dest 2) follows
    drive(1, 8'h03, 1, 0);
    cyc();
    drive(1, 8'h22, 1, 0);
    check("t4_d1_drop", 32'(drop_o), 0);
    cyc();
    drive(0, 8'h00, 1, 0);
    check("t4_d2_drop", 32'(drop_o), 1);
    check("t4_d2_en",   32'(xbar_dest_en_o), 0);
    cyc();
    check("t4_d3_drop", 32'(drop_o), 0);
    check("t4_d3_en",   32'(xbar_dest_en_o), 0);
    cyc();
    chk_req("t4_d4", 1, 2'd2, 8'h22);
    check("t4_d4_drop", 32'(drop_o), 0);
    cyc();
    chk_req("t4_d5", 0, 2'd0, 8'h00);
`ifdef NOC_INPORT_STATS_EN
    check("t4_stat_fwd",   stat_fwd_o,   7);
    check("t4_stat_stall", stat_stall_o, 6);
`endif
    cyc();

    // Reset while requesting with two flits queued
    drive(1, 8'h01, 0, 0);
    cyc();
    drive(1, 8'h02, 0, 0);
    cyc();
    drive(1, 8'h00, 0, 0);
    cyc();
    drive(0, 8'h00, 0, 0);
    check("t5_e3_en",    32'(xbar_dest_en_o), 1);
    check("t5_e3_count", 32'(count_o), 2);
    rst = 1'b1;
    cyc();
    chk_req("t5_e4", 0, 2'd0, 8'h00);
    check("t5_e4_count", 32'(count_o), 0);
    check("t5_e4_drop",  32'(drop_o),  0);
    check("t5_e4_ovf",   32'(ovf_o),   0);
    check("t5_e4_bp",    32'(in_bp_o), 0);
`ifdef NOC_INPORT_STATS_EN
    check("t5_stat_fwd",   stat_fwd_o,   0);
    check("t5_stat_stall", stat_stall_o, 0);
`endif
    rst = 1'b0;
    cyc();
    check("t5_e5_en", 32'(xbar_dest_en_o), 0);

    // Two transfers with five stalled request cycles
    drive(1, 8'h01, 0, 0);
    cyc();
    drive(0, 8'h00, 0, 0);
    cyc();
    cyc();
    chk_req("t6_s3", 1, 2'd1, 8'h01);
    cyc();
    cyc();
    cyc();
    drive(1, 8'h02, 1, 0);
    chk_req("t6_s6", 1, 2'd1, 8'h01);
    cyc();
    drive(0, 8'h00, 0, 0);
    check("t6_s7_en",    32'(xbar_dest_en_o), 0);
    check("t6_s7_count", 32'(count_o), 1);
    cyc();
    cyc();
    drive(0, 8'h00, 1, 1);
    chk_req("t6_s9", 1, 2'd2, 8'h02);
    cyc();
    cyc();
    drive(0, 8'h00, 1, 0);
    chk_req("t6_s11", 1, 2'd2, 8'h02);
    cyc();
    chk_req("t6_s12", 0, 2'd0, 8'h00);
    check("t6_s12_count", 32'(count_o), 0);
`ifdef NOC_INPORT_STATS_EN
    check("t6_stat_fwd",   stat_fwd_o,   2);
    check("t6_stat_stall", stat_stall_o, 5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
